reduction_stream_ctrl: RTL and testbench
========================================

Name: reduction_stream_ctrl

Overview:
- Sequences the 8-bit reduction datapath (AND/OR/NAND/NOR/XOR/XNOR) over multi-beat packets, so wide vectors can be reduced one word at a time.
- Accepts words on a valid/ready input stream, combines the per-beat reductions into running accumulators, and emits one registered 6-bit result per packet on a valid/ready output.
- Sits between a streaming data source and status/CSR logic that consumes packet-level parity and all-ones/all-zeros flags.

Parameters:
- DATA_W, 8: width of one input beat.
- MAX_BEATS, 16: maximum beats per packet before a forced close with overflow.
- CNT_W, 5: beat counter width; must hold MAX_BEATS.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  controller can accept a beat.
- s_data  in  DATA_W  input beat.
- s_last  in  1  final beat of the packet.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts the result.
- m_and  out  1  AND of all packet bits.
- m_or  out  1  OR of all packet bits.
- m_nand  out  1  ~m_and.
- m_nor  out  1  ~m_or.
- m_xor  out  1  XOR of all packet bits (odd number of ones).
- m_nxor  out  1  ~m_xor.
- m_ovf  out  1  packet was force-closed at MAX_BEATS without s_last.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 sampled at clk):
  - State goes to IDLE; beat count cleared.
  - Accumulators set to and=1, or=0, xor=0.
  - All outputs are 0, including s_ready, m_valid and busy. s_ready rises in the first cycle after reset is released.
- FSM states:
  - IDLE: no beat of the current packet accepted yet. s_ready=1.
  - ACCUM: at least one beat accepted. s_ready=1.
  - DONE: result held. s_ready=0, m_valid=1.
  - DRAIN: discarding the excess beats of an overflowed packet. s_ready=1.
- Beat accept happens when s_valid & s_ready in IDLE or ACCUM:
  - acc_and &= &s_data; acc_or |= |s_data; acc_xor ^= ^s_data.
  - In IDLE the update combines with the initial values (1/0/0), so the first beat fully defines the accumulators.
  - cnt increments.
- Packet close happens on an accepted beat with s_last=1, or on the accepted beat that makes cnt==MAX_BEATS:
  - The final accumulators, including that beat, load into the output registers. The FSM goes to DONE.
  - m_valid rises in the cycle after the closing beat is accepted (latency 1).
  - m_ovf=1 only if the close was caused by cnt reaching MAX_BEATS without s_last. If s_last and cnt==MAX_BEATS occur together, the result is a normal close with m_ovf=0.
- DONE:
  - m_* stay stable while m_valid & !m_ready.
  - On m_valid & m_ready: m_valid drops next cycle, accumulators and cnt reset. Next state is DRAIN if m_ovf, else IDLE.
  - The m_* data values hold their last value after the handshake.
- DRAIN: accepted beats are discarded (no accumulation). An accepted beat with s_last returns the FSM to IDLE.
- No back-to-back overlap: a new packet is not accepted while in DONE. Throughput is therefore 1 result per (beats + 1 + consumer wait) cycles.
- Zero-length packets do not exist; every packet is at least one beat.
- Reset mid-packet, in any state, discards the partial packet and all pending results.
- s_data and s_last are ignored when s_valid=0.

Optional Feature:
- Macro: REDUCTION_BEAT_CNT_EN.
- Defined:
  - Adds output port m_beats (CNT_W bits), registered together with m_* at packet close. It holds the number of accumulated beats: 1..MAX_BEATS, and MAX_BEATS on overflow.
  - m_beats resets to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Single beat, s_data=0xFF, s_last=1 -> next cycle m_valid=1 with and=1, or=1, nand=0, nor=0, xor=0, nxor=1, ovf=0; with REDUCTION_BEAT_CNT_EN, m_beats=1.
- Three beats 0xFF, 0x0F, 0x01 (last on the third) -> and=0, or=1, xor=1, nxor=1^1=0, ovf=0, m_beats=3.
- Two beats 0x00, 0x00 -> and=0, or=0, nor=1, xor=0, nxor=1. Then a single beat 0x07 -> xor=1, and=0, or=1, which proves the accumulators were cleared between packets.
- Back-pressure: hold m_ready=0 for 5 cycles after a result -> m_valid and m_* are stable and s_ready=0 throughout. Assert m_ready -> m_valid=0 and s_ready=1 in the next cycle.
- Overflow with MAX_BEATS=4: six beats of 0x01, last on beat 6 -> result after beat 4 with xor=0, and=0, or=1, ovf=1. Beats 5-6 are accepted and discarded in DRAIN. The next packet (0x03, last) gives xor=0, or=1, ovf=0.
- Reset mid-packet: accept 2 beats of 0xFF, pull rst_n low for one cycle -> m_valid=0 and s_ready=0 during reset. A following single-beat packet 0x80 gives and=0, or=1, xor=1.

Source files
------------

// File: rtl/reduction_stream_ctrl.sv
// Reduces multi-beat packets (AND/OR/XOR and complements) into one registered result per packet.
// Latency: result valid 1 cycle after the closing beat; optional m_beats port under REDUCTION_BEAT_CNT_EN.
// Backpressure: s_ready low while a result waits in DONE; m_* held stable until m_ready.
module reduction_stream_ctrl #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_and,
    output logic              m_or,
    output logic              m_nand,
    output logic              m_nor,
    output logic              m_xor,
    output logic              m_nxor,
    output logic              m_ovf,
    output logic              busy
`ifdef REDUCTION_BEAT_CNT_EN
    ,
    output logic [CNT_W-1:0]  m_beats
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE, DRAIN} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             acc_and_q, acc_or_q, acc_xor_q;
    logic             and_nxt, or_nxt, xor_nxt;
    logic             beat_hs;
    logic             accept;
    logic             close;
    logic             ovf_nxt;
    logic             res_hs;

    assign beat_hs = s_valid & s_ready;
    assign cnt_inc = cnt_q + 1'b1;

    // The first beat of a packet combines with the identity values, not whatever is left in the accumulators.
    always_comb begin
        and_nxt = (state_q == IDLE) ? (&s_data) : (acc_and_q & (&s_data));
        or_nxt  = (state_q == IDLE) ? (|s_data) : (acc_or_q  | (|s_data));
        xor_nxt = (state_q == IDLE) ? (^s_data) : (acc_xor_q ^ (^s_data));
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        close   = 1'b0;
        ovf_nxt = 1'b0;
        res_hs  = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (beat_hs) begin
                    accept  = 1'b1;
                    close   = s_last | (cnt_inc == MAX_CNT);
                    ovf_nxt = ~s_last & (cnt_inc == MAX_CNT);
                    state_d = close ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (m_ready) begin
                    res_hs  = 1'b1;
                    state_d = m_ovf ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (beat_hs && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_ready   <= 1'b0;
            cnt_q     <= '0;
            acc_and_q <= 1'b1;
            acc_or_q  <= 1'b0;
            acc_xor_q <= 1'b0;
            m_and     <= 1'b0;
            m_or      <= 1'b0;
            m_nand    <= 1'b0;
            m_nor     <= 1'b0;
            m_xor     <= 1'b0;
            m_nxor    <= 1'b0;
            m_ovf     <= 1'b0;
`ifdef REDUCTION_BEAT_CNT_EN
            m_beats   <= '0;
`endif
        end else begin
            state_q <= state_d;
            // Registered ready keeps s_ready low through the reset cycle and decouples it from m_ready.
            s_ready <= (state_d != DONE);
            if (accept) begin
                acc_and_q <= and_nxt;
                acc_or_q  <= or_nxt;
                acc_xor_q <= xor_nxt;
                cnt_q     <= cnt_inc;
            end
            if (close) begin
                m_and   <= and_nxt;
                m_or    <= or_nxt;
                m_nand  <= ~and_nxt;
                m_nor   <= ~or_nxt;
                m_xor   <= xor_nxt;
                m_nxor  <= ~xor_nxt;
                m_ovf   <= ovf_nxt;
`ifdef REDUCTION_BEAT_CNT_EN
                m_beats <= cnt_inc;
`endif
            end
            if (res_hs) begin
                acc_and_q <= 1'b1;
                acc_or_q  <= 1'b0;
                acc_xor_q <= 1'b0;
                cnt_q     <= '0;
            end
        end
    end

    assign m_valid = (state_q == DONE);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reduction_stream_ctrl.sv
// Randomized and directed bench for reduction_stream_ctrl against a packet-level reference model.
module tb_reduction_stream_ctrl;

    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic          m_and, m_or, m_nand, m_nor, m_xor, m_nxor, m_ovf;
    logic          busy;
`ifdef REDUCTION_BEAT_CNT_EN
    logic [CW-1:0] m_beats;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit a;
        bit o;
        bit x;
        bit v;
        int beats;
    } exp_t;

    reduction_stream_ctrl #(.DATA_W(DW), .MAX_BEATS(MB), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_and   (m_and),
        .m_or    (m_or),
        .m_nand  (m_nand),
        .m_nor   (m_nor),
        .m_xor   (m_xor),
        .m_nxor  (m_nxor),
        .m_ovf   (m_ovf),
        .busy    (busy)
`ifdef REDUCTION_BEAT_CNT_EN
        ,
        .m_beats (m_beats)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packet-level view: only the first MB beats count, judged by total ones.
    function automatic exp_t model(input bit [7:0] w[$]);
        exp_t e;
        int   n;
        int   ones;
        n    = (w.size() > MB) ? MB : w.size();
        ones = 0;
        for (int i = 0; i < n; i++) ones += $countones(w[i]);
        e.a     = (ones == 8 * n);
        e.o     = (ones != 0);
        e.x     = (ones % 2) == 1;
        e.v     = (w.size() > MB);
        e.beats = n;
        return e;
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, ".and"},  m_and,  e.a);
        chk({tag, ".or"},   m_or,   e.o);
        chk({tag, ".nand"}, m_nand, !e.a);
        chk({tag, ".nor"},  m_nor,  !e.o);
        chk({tag, ".xor"},  m_xor,  e.x);
        chk({tag, ".nxor"}, m_nxor, !e.x);
        chk({tag, ".ovf"},  m_ovf,  e.v);
`ifdef REDUCTION_BEAT_CNT_EN
        chk({tag, ".beats"}, m_beats, e.beats);
`endif
    endtask

    task automatic send_beat(input bit [7:0] d, input bit last);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("s_ready_timeout", 0, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic get_result(input string tag, input exp_t e, input int hold);
        int n;
        n       = 0;
        m_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".latency"}, m_valid, 1);
        while (!m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid) begin
            chk({tag, ".m_valid_timeout"}, 0, 1);
            return;
        end
        check_outs(tag, e);
        chk({tag, ".s_ready_done"}, s_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, m_valid, 1);
            chk({tag, ".hold_s_ready"}, s_ready, 0);
            check_outs({tag, ".hold"}, e);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".valid_drop"}, m_valid, 0);
        chk({tag, ".s_ready_after"}, s_ready, 1);
        check_outs({tag, ".after"}, e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_pkt(input string tag, input bit [7:0] w[$], input int hold, input bit gaps);
        exp_t e;
        int   close_idx;
        e         = model(w);
        close_idx = e.beats - 1;
        for (int i = 0; i < w.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(w[i], i == w.size() - 1);
            if (i == close_idx) get_result(tag, e, hold);
        end
        if (e.v) begin
            @(negedge clk);
            chk({tag, ".drain_idle"}, busy, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit [7:0] q[$];
        string    tag;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.s_ready", s_ready, 0);
        chk("rst.m_valid", m_valid, 0);
        chk("rst.busy",    busy,    0);
        chk("rst.m_nand",  m_nand,  0);
        chk("rst.m_nxor",  m_nxor,  0);
        chk("rst.m_ovf",   m_ovf,   0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.s_ready_rise", s_ready, 1);
        @(posedge clk);
        #1;

        q = {8'hFF};
        run_pkt("single_ff", q, 0, 0);
        q = {8'hFF, 8'h0F, 8'h01};
        run_pkt("three", q, 0, 0);
        q = {8'h00, 8'h00};
        run_pkt("zeros", q, 0, 0);
        q = {8'h07};
        run_pkt("after_zeros", q, 0, 0);
        q = {8'hA5};
        run_pkt("backpressure", q, 5, 0);
        q = {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        run_pkt("overflow", q, 1, 0);
        q = {8'h03};
        run_pkt("post_ovf", q, 0, 0);
        q = {8'hF0, 8'hF0, 8'hF0, 8'hF1};
        run_pkt("exact_max", q, 0, 0);

        send_beat(8'hFF, 1'b0);
        @(negedge clk);
        chk("midrst.busy_before", busy, 1);
        @(posedge clk);
        #1;
        send_beat(8'hFF, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.m_valid", m_valid, 0);
        chk("midrst.s_ready", s_ready, 0);
        chk("midrst.busy",    busy,    0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q = {8'h80};
        run_pkt("after_rst", q, 0, 0);

        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, MB + 2);
            q.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       q.push_back(8'h00);
                    1:       q.push_back(8'hFF);
                    default: q.push_back(8'($urandom));
                endcase
            end
            tag = $sformatf("rnd%0d", p);
            run_pkt(tag, q, $urandom_range(0, 3), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
